// File: rtl/iobus_sseg_ctrl.sv
// iobus_sseg_ctrl: IOBUS-mapped 4-digit multiplexed seven-segment display controller
// DATA/CTRL registers, frame-synchronous shadow copy, registered anode/cathode drive.
module iobus_sseg_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h110C0000,
    parameter int          REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] iobus_addr,
    input  logic [31:0] iobus_out,
    input  logic        iobus_wr,
    output logic [31:0] iobus_rd,
    output logic [7:0]  segs,
    output logic [3:0]  an
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [111:0] SEG_LUT = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    logic [15:0]   r_data, r_shadow;
    logic [7:0]    r_ctrl;
    logic [RW-1:0] r_rcnt;
    logic [1:0]    r_dig;
    logic [3:0]    r_an;
    logic [7:0]    r_segs;
    logic          w_sel_data, w_sel_ctrl, w_tick, w_blank;
    logic [3:0]    w_nib, w_dpm;
    logic [15:0]   w_upper;
    logic [7:0]    w_segs;

    assign w_sel_data = iobus_addr == BASE_ADDR;
    assign w_sel_ctrl = iobus_addr == BASE_ADDR + 32'd4;
    assign iobus_rd   = w_sel_data ? {16'b0, r_data} : w_sel_ctrl ? {24'b0, r_ctrl} : 32'b0;
    assign w_tick     = r_rcnt == RW'(REFRESH_DIV - 1);
    assign w_upper    = r_shadow >> {r_dig, 2'b00};
    assign w_nib      = w_upper[3:0];
    assign w_dpm      = r_ctrl[7:4];
    // Leading-zero blank: this digit and everything to its left is zero.
    assign w_blank    = r_ctrl[1] && r_dig != 2'd0 && w_upper == 16'd0;
    assign w_segs     = w_blank ? 8'hFF : {~w_dpm[r_dig], SEG_LUT[7*w_nib +: 7]};
    assign an         = r_an;
    assign segs       = r_segs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= '0;
            r_ctrl   <= '0;
            r_shadow <= '0;
            r_rcnt   <= '0;
            r_dig    <= '0;
            r_an     <= 4'hF;
            r_segs   <= 8'hFF;
        end else begin
            if (iobus_wr && w_sel_data) r_data <= iobus_out[15:0];
            if (iobus_wr && w_sel_ctrl) r_ctrl <= iobus_out[7:0];
            if (!r_ctrl[0]) begin
                r_rcnt   <= '0;
                r_dig    <= '0;
                r_shadow <= r_data;
                r_an     <= 4'hF;
                r_segs   <= 8'hFF;
            end else begin
                r_rcnt <= w_tick ? '0 : r_rcnt + 1'b1;
                if (w_tick) r_dig <= r_dig + 2'd1;
                // r_data here is the pre-write value, so a same-cycle write lands next frame.
                if (w_tick && r_dig == 2'd3) r_shadow <= r_data;
                r_an   <= ~(4'b0001 << r_dig);
                r_segs <= w_segs;
            end
        end
    end
endmodule
